time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Timekeeping core of the Millennium Clock.
- Divides the system clock down to a 1 Hz tick and keeps hours/minutes/seconds in plain binary.
- Provides a button-driven set mode for adjusting the time.
- Its 6-bit sec/min/hour outputs feed the bin2bcd converters directly; each field is 0..59 or 0..23, so it fits the 6-bit converter input.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock cycles per second; prescaler terminal count is CLK_FREQ_HZ-1; must be >= 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_mode  input  1  single-cycle pulse (already debounced/edge-detected); advances set-mode state
- btn_inc  input  1  single-cycle pulse; increments the selected field in set mode
- sec  output  6  seconds, binary 0..59
- min  output  6  minutes, binary 0..59
- hour  output  6  hours, binary 0..23
- tick_1hz  output  1  one-cycle pulse when the prescaler wraps
- day_wrap  output  1  one-cycle pulse when time rolls 23:59:59 -> 00:00:00 by counting; not by set-mode increments
- mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC; display uses it to blink the field

Behaviour:
- Reset (async, any time incl. mid-set):
  - sec=min=hour=0, prescaler=0, tick_1hz=0, day_wrap=0, mode=RUN.
  - Takes effect immediately, without waiting for a clock edge.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1 in RUN only.
  - tick_1hz is registered: it is high the cycle after the count hits terminal.
  - Time fields advance in the same edge that raises tick_1hz.
  - In set states the prescaler holds at 0 and tick_1hz stays 0.
- Counting on tick (RUN):
  - sec+1.
  - sec 59 -> 0 carries into min; min 59 -> 0 carries into hour; hour 23 -> 0.
  - The full carry chain resolves in one cycle: 23:59:59 -> 00:00:00 in a single edge, with day_wrap=1 that same cycle.
- FSM, advanced by btn_mode: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - Entering SET_HOUR clears the prescaler.
  - Leaving SET_SEC also clears the prescaler, so the first tick comes a full second after resume.
- btn_inc in a set state:
  - Increments the selected field modulo its range (hour 23 -> 0, min/sec 59 -> 0).
  - No carry into other fields; no day_wrap.
  - btn_inc in RUN is ignored.
- Simultaneous events:
  - btn_inc and btn_mode in the same cycle in a set state: the increment applies to the field selected before the transition, then the state advances.
  - Tick and btn_mode in the same cycle in RUN: the tick increment is applied, then the state moves to SET_HOUR.
- Latency: sec/min/hour/mode are registered and change on the edge where the triggering event is sampled. No combinational input-to-output paths.
- Out-of-range values are unreachable; no field may ever exceed its maximum.

Decomposition:
- Package clock_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, FIELD_W=6;
  - the mode state encoding (RUN/SET_HOUR/SET_MIN/SET_SEC as 2-bit constants).
- Sub-module mod_counter, instanced three times:
  - parameter MAX; ports clk, rst, en, value[FIELD_W-1:0], carry;
  - wraps MAX -> 0 and asserts carry combinationally when en and value==MAX.
- Prescaler and FSM live in time_counter.

Test Plan (CLK_FREQ_HZ=4):
- Assert rst mid-count at 00:00:07 → all outputs 0 and mode=0 asynchronously. Release, then run 4 clocks → tick_1hz pulses once and sec=1.
- Run 60 ticks from 00:00:00 → 00:01:00 exactly when the 60th tick_1hz is high; min carry happens in the same cycle.
- Preload via set mode to 23:59:59, return to RUN, wait one tick → 00:00:00 with day_wrap=1 for exactly one cycle.
- btn_mode once, then btn_inc 25 times → mode=1, hour=1 (wraps past 23), min/sec unchanged, tick_1hz never asserted while in set mode.
- In SET_SEC with sec=59, pulse btn_inc and btn_mode in the same cycle → sec=0, min unchanged, mode=RUN; next tick_1hz exactly 4 clocks later.
- btn_inc while in RUN at 00:00:05 → no change; btn_mode coincident with tick → sec=6 and mode=1 on that same edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and the set-mode state encoding for the Millennium Clock
// timekeeping core.
package clock_pkg;

  // Field width used by every time field and by the downstream bin2bcd input.
  localparam int FIELD_W  = 6;

  // Inclusive maximum value of each field before it wraps to zero.
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Operating mode; the encoding is exported on the mode port so the display
  // can blink the field currently being adjusted.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  // Mode sequence walked by btn_mode: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      default:  return RUN;
    endcase
  endfunction

endpackage : clock_pkg

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up counter used for the seconds, minutes and hours fields.
// carry flags the enabled wrap so the caller can chain fields in one cycle.
module mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = SEC_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [FIELD_W-1:0] value,
  output logic               carry
);

  localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX);

  // Wrap decision; >= rather than == keeps the field in range even if it were
  // ever disturbed, while carry still only fires on the genuine MAX -> 0 step.
  logic wrap;
  assign wrap  = (value >= MAX_V);
  assign carry = en && (value == MAX_V);

  // Field register: advance on enable, wrapping to zero past MAX.
  // NOTE: sequential state is written with <= so every register in the design
  // samples pre-edge values; blocking writes here would race the carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + FIELD_W'(1);
    end
  end

endmodule : mod_counter

// File: rtl/time_counter.sv
// Timekeeping core: divides clk down to a 1 Hz tick, keeps hh:mm:ss in binary
// and provides a button-driven set mode for adjusting each field.
module time_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] hour,
  output logic               tick_1hz,
  output logic               day_wrap,
  output logic [1:0]         mode
);

  // Prescaler sizing; CLK_FREQ_HZ >= 2 keeps PW at least one bit.
  localparam int            PW   = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_FREQ_HZ - 1);

  mode_t         state;
  mode_t         state_next;
  logic [PW-1:0] presc;

  logic tick_now;
  logic in_run;
  logic sec_en, min_en, hour_en;
  logic sec_carry, min_carry, hour_carry;

  assign in_run   = (state == RUN);

  // The second boundary: fields advance on this edge and tick_1hz rises with it.
  assign tick_now = in_run && (presc == TERM);

  // Counting chains carries through all three fields in one cycle; set-mode
  // increments touch only the selected field and never propagate a carry.
  assign sec_en  = tick_now || ((state == SET_SEC) && btn_inc);
  assign min_en  = (tick_now && sec_carry) || ((state == SET_MIN) && btn_inc);
  assign hour_en = (tick_now && min_carry) || ((state == SET_HOUR) && btn_inc);

  mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .en    (sec_en),
    .value (sec),
    .carry (sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .en    (min_en),
    .value (min),
    .carry (min_carry)
  );

  mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .en    (hour_en),
    .value (hour),
    .carry (hour_carry)
  );

  // Prescaler: counts only in RUN; held at zero in set states and cleared when
  // leaving RUN, so a resume always waits a full second for its first tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (in_run && !btn_mode) begin
      presc <= tick_now ? '0 : presc + PW'(1);
    end else begin
      presc <= '0;
    end
  end

  // Registered event pulses; day_wrap only on a counted midnight roll-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_1hz <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      tick_1hz <= tick_now;
      day_wrap <= tick_now && hour_carry;
    end
  end

  // Mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-mode logic: btn_mode steps through the set sequence.
  // NOTE: state_next is defaulted before any condition so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (btn_mode) begin
      state_next = next_mode(state);
    end
  end

  assign mode = state;

endmodule : time_counter

// File: tb/tb_time_counter.sv
// Directed testbench for time_counter with a 4-cycle second (CLK_FREQ_HZ=4).
module tb_time_counter;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic       tick_1hz;
  logic       day_wrap;
  logic [1:0] mode;

  int errors;
  int checks;
  logic seen_tick;
  logic seen_wrap;

  time_counter #(.CLK_FREQ_HZ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .tick_1hz (tick_1hz),
    .day_wrap (day_wrap),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
  endtask

  // Back-to-back increment pulses, recording any tick/day_wrap seen meanwhile.
  task automatic inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step(1);
      btn_inc = 1'b0;
      if (tick_1hz) seen_tick = 1'b1;
      if (day_wrap) seen_wrap = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++; if ({hour, min, sec} !== 18'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hour, min, sec); end
    checks++; if ({mode, tick_1hz, day_wrap} !== 4'd0) begin errors++; $display("FAIL reset_flags: got mode=%0d tick=%0b wrap=%0b expected 0 0 0", mode, tick_1hz, day_wrap); end
    rst = 1'b0;
    step(28);
    checks++; if (sec !== 6'd7) begin errors++; $display("FAIL run7_sec: got %0d expected 7", sec); end
    step(2);
    rst = 1'b1;
    #1;
    checks++; if ({hour, min, sec} !== 18'd0) begin errors++; $display("FAIL async_reset_time: got %0d:%0d:%0d expected 0:0:0", hour, min, sec); end
    checks++; if ({mode, tick_1hz, day_wrap} !== 4'd0) begin errors++; $display("FAIL async_reset_flags: got mode=%0d tick=%0b wrap=%0b expected 0 0 0", mode, tick_1hz, day_wrap); end
    rst = 1'b0;
    step(3);
    checks++; if ({tick_1hz, sec} !== {1'b0, 6'd0}) begin errors++; $display("FAIL pre_tick: got tick=%0b sec=%0d expected tick=0 sec=0", tick_1hz, sec); end
    step(1);
    checks++; if ({tick_1hz, sec} !== {1'b1, 6'd1}) begin errors++; $display("FAIL first_tick: got tick=%0b sec=%0d expected tick=1 sec=1", tick_1hz, sec); end
    step(1);
    checks++; if (tick_1hz !== 1'b0) begin errors++; $display("FAIL tick_width: got %0b expected 0", tick_1hz); end
  endtask

  task automatic test_min_carry();
    do_reset();
    step(236);
    checks++; if ({min, sec} !== {6'd0, 6'd59}) begin errors++; $display("FAIL min_carry_pre: got %0d:%0d expected 0:59", min, sec); end
    step(3);
    checks++; if ({tick_1hz, sec} !== {1'b0, 6'd59}) begin errors++; $display("FAIL min_carry_hold: got tick=%0b sec=%0d expected tick=0 sec=59", tick_1hz, sec); end
    step(1);
    checks++; if ({tick_1hz, hour, min, sec} !== {1'b1, 6'd0, 6'd1, 6'd0}) begin errors++; $display("FAIL min_carry: got tick=%0b %0d:%0d:%0d expected tick=1 0:1:0", tick_1hz, hour, min, sec); end
  endtask

  task automatic test_day_wrap();
    do_reset();
    seen_tick = 1'b0;
    seen_wrap = 1'b0;
    pulse_mode();
    inc(23);
    pulse_mode();
    inc(59);
    pulse_mode();
    inc(59);
    pulse_mode();
    checks++; if ({mode, hour, min, sec} !== {2'd0, 6'd23, 6'd59, 6'd59}) begin errors++; $display("FAIL preload: got mode=%0d %0d:%0d:%0d expected mode=0 23:59:59", mode, hour, min, sec); end
    checks++; if ({seen_tick, seen_wrap} !== 2'b00) begin errors++; $display("FAIL preload_pulses: got tick_seen=%0b wrap_seen=%0b expected 0 0", seen_tick, seen_wrap); end
    step(3);
    checks++; if ({day_wrap, sec} !== {1'b0, 6'd59}) begin errors++; $display("FAIL wrap_hold: got wrap=%0b sec=%0d expected wrap=0 sec=59", day_wrap, sec); end
    step(1);
    checks++; if ({hour, min, sec} !== 18'd0) begin errors++; $display("FAIL day_roll: got %0d:%0d:%0d expected 0:0:0", hour, min, sec); end
    checks++; if ({day_wrap, tick_1hz} !== 2'b11) begin errors++; $display("FAIL day_wrap_pulse: got wrap=%0b tick=%0b expected 1 1", day_wrap, tick_1hz); end
    step(1);
    checks++; if (day_wrap !== 1'b0) begin errors++; $display("FAIL day_wrap_width: got %0b expected 0", day_wrap); end
  endtask

  task automatic test_set_hour_wrap();
    do_reset();
    step(12);
    seen_tick = 1'b0;
    seen_wrap = 1'b0;
    pulse_mode();
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL enter_set_hour: got mode=%0d expected 1", mode); end
    inc(25);
    checks++; if ({mode, hour, min, sec} !== {2'd1, 6'd1, 6'd0, 6'd3}) begin errors++; $display("FAIL set_hour_wrap: got mode=%0d %0d:%0d:%0d expected mode=1 1:0:3", mode, hour, min, sec); end
    step(10);
    if (tick_1hz) seen_tick = 1'b1;
    checks++; if ({seen_tick, seen_wrap} !== 2'b00) begin errors++; $display("FAIL set_no_pulses: got tick_seen=%0b wrap_seen=%0b expected 0 0", seen_tick, seen_wrap); end
    checks++; if (sec !== 6'd3) begin errors++; $display("FAIL set_hold_sec: got %0d expected 3", sec); end
  endtask

  // Continues from test_set_hour_wrap: SET_HOUR at 01:00:03.
  task automatic test_inc_with_mode();
    pulse_mode();
    pulse_mode();
    checks++; if (mode !== 2'd3) begin errors++; $display("FAIL enter_set_sec: got mode=%0d expected 3", mode); end
    inc(56);
    checks++; if (sec !== 6'd59) begin errors++; $display("FAIL set_sec_59: got %0d expected 59", sec); end
    btn_inc  = 1'b1;
    btn_mode = 1'b1;
    step(1);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    checks++; if ({mode, hour, min, sec} !== {2'd0, 6'd1, 6'd0, 6'd0}) begin errors++; $display("FAIL inc_and_mode: got mode=%0d %0d:%0d:%0d expected mode=0 1:0:0", mode, hour, min, sec); end
    checks++; if (day_wrap !== 1'b0) begin errors++; $display("FAIL set_wrap_no_day: got %0b expected 0", day_wrap); end
    step(3);
    checks++; if (tick_1hz !== 1'b0) begin errors++; $display("FAIL resume_early_tick: got %0b expected 0", tick_1hz); end
    step(1);
    checks++; if ({tick_1hz, sec} !== {1'b1, 6'd1}) begin errors++; $display("FAIL resume_tick: got tick=%0b sec=%0d expected tick=1 sec=1", tick_1hz, sec); end
  endtask

  task automatic test_run_inc_and_tick_mode();
    do_reset();
    step(20);
    checks++; if (sec !== 6'd5) begin errors++; $display("FAIL run_sec5: got %0d expected 5", sec); end
    inc(1);
    checks++; if ({mode, hour, min, sec} !== {2'd0, 6'd0, 6'd0, 6'd5}) begin errors++; $display("FAIL run_inc_ignored: got mode=%0d %0d:%0d:%0d expected mode=0 0:0:5", mode, hour, min, sec); end
    step(2);
    pulse_mode();
    checks++; if ({mode, sec} !== {2'd1, 6'd6}) begin errors++; $display("FAIL tick_with_mode: got mode=%0d sec=%0d expected mode=1 sec=6", mode, sec); end
    step(8);
    checks++; if ({mode, sec} !== {2'd1, 6'd6}) begin errors++; $display("FAIL set_hold_after_tick: got mode=%0d sec=%0d expected mode=1 sec=6", mode, sec); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    seen_tick = 1'b0;
    seen_wrap = 1'b0;
    test_reset();
    test_min_carry();
    test_day_wrap();
    test_set_hour_wrap();
    test_inc_with_mode();
    test_run_inc_and_tick_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_time_counter
